// File: rtl/clk_sw_pkg.sv
// Shared types and helpers for the clock-enable channel switch.
package clk_sw_pkg;

  // Switch FSM states: normal capture, one-cycle drain, programmable dead gap
  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    DRAIN  = 2'd1,
    GAP    = 2'd2
  } sw_state_e;

  // Gap counter width; covers a dead gap of 0..15 cycles
  localparam int CNT_W = 4;

  // Bit offset of channel idx inside a packed per-channel data bus
  function automatic int unsigned chan_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/clk_sw_gap_cnt.sv
// Loadable down-counter that times the dead gap between deselect and reselect.
module clk_sw_gap_cnt
  import clk_sw_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Load has priority; decrement saturates at zero so a stray dec cannot wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign value = cnt_r;
  assign zero  = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/clk_en_switch.sv
// Selects one of N_CH enable/data channels and captures its data on enabled
// cycles. Channel changes go through DRAIN and a dead GAP so no capture ever
// mixes the old and new source.
module clk_en_switch
  import clk_sw_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 8,
  parameter int GAP_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sel_req,
  input  logic [$clog2(N_CH)-1:0] sel_id,
  input  logic [N_CH-1:0]         en_in,
  input  logic [N_CH*WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]        data_out,
  output logic                    data_vld,
  output logic [$clog2(N_CH)-1:0] cur_sel,
  output logic                    sel_busy,
  output logic                    switch_done,
  output logic                    sel_err
);

  localparam int SEL_W = $clog2(N_CH);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : {CNT_W{1'b0}};

  sw_state_e        state_r;
  logic [SEL_W-1:0] pend_r;
  logic             load_s;
  logic             dec_s;
  logic [CNT_W-1:0] cnt_val_s;
  logic             cnt_zero_s;
  logic [WIDTH-1:0] sel_data_s;
  logic             sel_en_s;

  // Mux out the active channel's enable and data using constant slice offsets
  always_comb begin
    sel_data_s = {WIDTH{1'b0}};
    sel_en_s   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (cur_sel == SEL_W'(k)) begin
        sel_data_s = data_in[chan_lsb(k, WIDTH) +: WIDTH];
        sel_en_s   = en_in[k];
      end else begin
        sel_data_s = sel_data_s;
        sel_en_s   = sel_en_s;
      end
    end
  end

  // Gap counter is loaded in DRAIN and counted down in GAP
  always_comb begin
    load_s = 1'b0;
    dec_s  = 1'b0;
    if (state_r == DRAIN) begin
      load_s = 1'b1;
    end else if (state_r == GAP) begin
      dec_s = 1'b1;
    end else begin
      load_s = 1'b0;
      dec_s  = 1'b0;
    end
  end

  clk_sw_gap_cnt u_gap_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .dec      (dec_s),
    .load_val (GAP_LOAD),
    .value    (cnt_val_s),
    .zero     (cnt_zero_s)
  );

  // Switch FSM with capture path; every output is a register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ACTIVE;
      pend_r      <= {SEL_W{1'b0}};
      cur_sel     <= {SEL_W{1'b0}};
      data_out    <= {WIDTH{1'b0}};
      data_vld    <= 1'b0;
      sel_busy    <= 1'b0;
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      data_vld    <= 1'b0;
      switch_done <= 1'b0;
      sel_err     <= 1'b0;
      case (state_r)
        ACTIVE: begin
          // A capture from the old channel and a request in the same cycle are both honoured
          if (sel_en_s) begin
            data_out <= sel_data_s;
            data_vld <= 1'b1;
          end
          if (sel_req) begin
            if (int'(sel_id) >= N_CH) begin
              sel_err <= 1'b1;
            end else if (sel_id == cur_sel) begin
              switch_done <= 1'b1;
            end else begin
              pend_r   <= sel_id;
              state_r  <= DRAIN;
              sel_busy <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (GAP_CYC == 0) begin
            state_r     <= ACTIVE;
            cur_sel     <= pend_r;
            switch_done <= 1'b1;
            sel_busy    <= 1'b0;
          end else begin
            state_r <= GAP;
          end
        end
        GAP: begin
          // An out-of-range count also ends the gap so the FSM cannot stall
          if (cnt_zero_s || (cnt_val_s > GAP_LOAD)) begin
            state_r     <= ACTIVE;
            cur_sel     <= pend_r;
            switch_done <= 1'b1;
            sel_busy    <= 1'b0;
          end
        end
        default: begin
          state_r  <= ACTIVE;
          sel_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_en_switch.sv
// Self-checking bench for clk_en_switch: scoreboard for captured data plus
// directed checks of the switch handshake, with GAP_CYC=2 and GAP_CYC=0 builds.
module tb_clk_en_switch;

  localparam int N_CH  = 4;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             sel_req;
  logic [1:0]       sel_id;
  logic             sel_req0;
  logic [1:0]       sel_id0;
  logic [N_CH-1:0]  en_in;
  logic [N_CH*WIDTH-1:0] data_in;

  logic [WIDTH-1:0] data_out,  data_out0;
  logic             data_vld,  data_vld0;
  logic [1:0]       cur_sel,   cur_sel0;
  logic             sel_busy,  sel_busy0;
  logic             switch_done, switch_done0;
  logic             sel_err,   sel_err0;

  int n_err;
  int n_chk;
  int cyc;
  logic [WIDTH-1:0] exp_data[$];
  int               exp_cyc[$];

  clk_en_switch #(.N_CH(N_CH), .WIDTH(WIDTH), .GAP_CYC(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req), .sel_id(sel_id),
    .en_in(en_in), .data_in(data_in), .data_out(data_out), .data_vld(data_vld),
    .cur_sel(cur_sel), .sel_busy(sel_busy), .switch_done(switch_done), .sel_err(sel_err)
  );

  clk_en_switch #(.N_CH(N_CH), .WIDTH(WIDTH), .GAP_CYC(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .sel_req(sel_req0), .sel_id(sel_id0),
    .en_in(en_in), .data_in(data_in), .data_out(data_out0), .data_vld(data_vld0),
    .cur_sel(cur_sel0), .sel_busy(sel_busy0), .switch_done(switch_done0), .sel_err(sel_err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to time scoreboard entries
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [WIDTH-1:0] v);
    data_in[k*WIDTH +: WIDTH] = v;
  endtask

  // Expect a capture of v on the edge that samples the current inputs
  task automatic expect_cap(input logic [WIDTH-1:0] v);
    exp_data.push_back(v);
    exp_cyc.push_back(cyc + 1);
  endtask

  // Scoreboard monitor on the falling edge, away from the sampling edge
  always @(negedge clk) begin
    if (rst_n && data_vld) begin
      if (exp_data.size() == 0) begin
        chk("unexpected_vld", {24'd0, data_out}, 32'd0);
      end else begin
        chk("cap_data", {24'd0, data_out}, {24'd0, exp_data.pop_front()});
        chk("cap_cycle", cyc, exp_cyc.pop_front());
      end
    end
    if (rst_n && sel_err) chk("sel_err", 32'd1, 32'd0);
  end

  initial begin
    cyc      = 0;
    n_err    = 0;
    n_chk    = 0;
    rst_n    = 1'b0;
    sel_req  = 1'b0;
    sel_id   = 2'd0;
    sel_req0 = 1'b0;
    sel_id0  = 2'd0;
    en_in    = 4'b0000;
    data_in  = 32'h0;
    tick();
    tick();
    chk("rst_cur_sel", {30'd0, cur_sel}, 32'd0);
    chk("rst_data_out", {24'd0, data_out}, 32'd0);
    chk("rst_flags", {28'd0, data_vld, sel_busy, switch_done, sel_err}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Capture from channel 0
    set_ch(0, 8'h5A);
    en_in = 4'b0001;
    expect_cap(8'h5A);
    tick();
    en_in = 4'b0000;
    chk("cap0_vld", {31'd0, data_vld}, 32'd1);
    tick();
    chk("cap0_vld_pulse", {31'd0, data_vld}, 32'd0);
    chk("cap0_data_hold", {24'd0, data_out}, 32'h5A);

    // Same-channel request: immediate done, never busy
    sel_req = 1'b1;
    sel_id  = 2'd0;
    tick();
    sel_req = 1'b0;
    chk("same_done", {31'd0, switch_done}, 32'd1);
    chk("same_busy", {31'd0, sel_busy}, 32'd0);
    chk("same_cur_sel", {30'd0, cur_sel}, 32'd0);
    tick();
    chk("same_done_pulse", {31'd0, switch_done}, 32'd0);

    // Switch to channel 2; enables during the switch must be masked
    sel_req = 1'b1;
    sel_id  = 2'd2;
    tick();
    sel_req = 1'b0;
    set_ch(2, 8'hC3);
    for (int i = 0; i < 3; i++) begin
      chk("sw2_busy", {31'd0, sel_busy}, 32'd1);
      chk("sw2_no_done", {31'd0, switch_done}, 32'd0);
      chk("sw2_old_sel", {30'd0, cur_sel}, 32'd0);
      en_in = 4'b0100;
      tick();
    end
    chk("sw2_done", {31'd0, switch_done}, 32'd1);
    chk("sw2_cur_sel", {30'd0, cur_sel}, 32'd2);
    chk("sw2_idle", {31'd0, sel_busy}, 32'd0);
    expect_cap(8'hC3);
    tick();
    en_in = 4'b0000;
    chk("sw2_done_pulse", {31'd0, switch_done}, 32'd0);
    chk("sw2_cap_data", {24'd0, data_out}, 32'hC3);

    // Request during GAP is ignored, switch completes to original target
    sel_req = 1'b1;
    sel_id  = 2'd3;
    tick();
    sel_req = 1'b0;
    tick();
    sel_req = 1'b1;
    sel_id  = 2'd1;
    tick();
    sel_req = 1'b0;
    tick();
    chk("gapreq_done", {31'd0, switch_done}, 32'd1);
    chk("gapreq_cur_sel", {30'd0, cur_sel}, 32'd3);
    tick();
    chk("gapreq_not_queued_busy", {31'd0, sel_busy}, 32'd0);
    chk("gapreq_not_queued_sel", {30'd0, cur_sel}, 32'd3);

    // GAP_CYC=0 build: done two cycles after request
    sel_req0 = 1'b1;
    sel_id0  = 2'd3;
    tick();
    sel_req0 = 1'b0;
    chk("g0_busy", {31'd0, sel_busy0}, 32'd1);
    chk("g0_no_done", {31'd0, switch_done0}, 32'd0);
    tick();
    chk("g0_done", {31'd0, switch_done0}, 32'd1);
    chk("g0_cur_sel", {30'd0, cur_sel0}, 32'd3);
    chk("g0_idle", {31'd0, sel_busy0}, 32'd0);

    // Move to channel 1, then drive all enables with distinct data
    sel_req = 1'b1;
    sel_id  = 2'd1;
    tick();
    sel_req = 1'b0;
    tick();
    tick();
    tick();
    chk("sw1_cur_sel", {30'd0, cur_sel}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < N_CH; k++) set_ch(k, 8'((k + 1) * 16 + i));
      en_in = 4'b1111;
      expect_cap(8'(2 * 16 + i));
      tick();
    end
    en_in = 4'b0000;
    tick();
    chk("sb_drained", exp_data.size(), 32'd0);

    // Reset asserted in GAP: asynchronous clear, no late switch_done
    sel_req = 1'b1;
    sel_id  = 2'd2;
    tick();
    sel_req = 1'b0;
    tick();
    chk("pre_rst_busy", {31'd0, sel_busy}, 32'd1);
    rst_n = 1'b0;
    #2;
    chk("arst_cur_sel", {30'd0, cur_sel}, 32'd0);
    chk("arst_data_out", {24'd0, data_out}, 32'd0);
    chk("arst_flags", {28'd0, data_vld, sel_busy, switch_done, sel_err}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_no_done", {31'd0, switch_done}, 32'd0);
      chk("post_rst_sel", {30'd0, cur_sel}, 32'd0);
    end
    chk("sb_final", exp_data.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
